alu_sequencer: RTL and testbench

- Multi-cycle control sequencer; drives the combinational ALU's opcode/func/flag inputs and consumes its flag, overflow and branch outputs.
- Fetches 9-bit instructions through an instruction-memory handshake and decodes them.
- Owns the architectural FLAG and OVERFLOW registers and the PC.
- Sequences data-memory handshakes for loads/stores and register-file write-back.

---
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for a combinational ALU: fetch/decode/execute,
// data-memory handshake, register write-back, and PC/FLAG/OVERFLOW ownership.
module alu_sequencer #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] HALT_ADDR = {PC_W{1'b1}}
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [8:0]      IMEM_DATA,
  output logic [2:0]      ALU_OP,
  output logic [2:0]      ALU_FUNC,
  output logic            ALU_FLAG_IN,
  output logic            ALU_OVF_IN,
  input  logic            ALU_FLAG_OUT,
  input  logic            ALU_OVF_OUT,
  input  logic            ALU_BR_EN,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  input  logic            DMEM_ACK,
  output logic            REG_WE,
  output logic [2:0]      REG_WADDR,
  output logic            DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_CEQ = 3'b100;
  localparam logic [2:0] OP_CLT = 3'b101;
  localparam logic [2:0] OP_O   = 3'b111;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [8:0]      instr_q;
  logic            flag_q, ovf_q, br_q;
  logic            imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, done_q;
  logic [2:0]      alu_op_q, alu_func_q;

  logic [2:0]      op;
  logic            is_mem, is_br, taken_d, advance_d, halt_d;
  logic [PC_W-1:0] pc_d, offset;

  always_comb begin
    op       = instr_q[8:6];
    is_mem   = (op == OP_LW) || (op == OP_SW);
    // B0/B1 are the only O-type functions with FUNC[2:1] == 2'b11
    is_br    = (op == OP_CEQ) || (op == OP_CLT) ||
               ((op == OP_O) && (instr_q[2:1] == 2'b11));
    // The branch decision is live in EXEC and remembered for later PC updates
    taken_d  = (state_q == S_EXEC) ? ALU_BR_EN : br_q;
    offset   = taken_d ? {{(PC_W-3){instr_q[5]}}, instr_q[5:3]} : '0;
    pc_d     = pc_q + PC_W'(1) + offset;
    halt_d   = (pc_d == HALT_ADDR);
    advance_d = (state_q == S_WB) ||
                ((state_q == S_EXEC) && is_br) ||
                ((state_q == S_MEM) && DMEM_ACK && (op == OP_SW));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      flag_q     <= 1'b0;
      ovf_q      <= 1'b0;
      br_q       <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      done_q     <= 1'b0;
      alu_op_q   <= '0;
      alu_func_q <= '0;
    end else begin
      reg_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (IMEM_ACK) begin
            instr_q    <= IMEM_DATA;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_op_q   <= instr_q[8:6];
          alu_func_q <= instr_q[2:0];
          state_q    <= S_EXEC;
        end
        S_EXEC: begin
          flag_q <= ALU_FLAG_OUT;
          ovf_q  <= ALU_OVF_OUT;
          br_q   <= ALU_BR_EN;
          if (is_mem) begin
            state_q    <= S_MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (op == OP_SW);
          end else if (!is_br) begin
            state_q  <= S_WB;
            reg_we_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (DMEM_ACK) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (op == OP_LW) begin
              state_q  <= S_WB;
              reg_we_q <= 1'b1;
            end
          end
        end
        S_WB: begin
        end
        S_HALT: begin
          if (START) begin
            pc_q       <= '0;
            done_q     <= 1'b0;
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Common PC update for WB, branch/compare EXEC and store completion
      if (advance_d) begin
        pc_q <= pc_d;
        if (halt_d) begin
          state_q <= S_HALT;
          done_q  <= 1'b1;
        end else begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
      end
    end
  end

  assign IMEM_REQ    = imem_req_q;
  assign IMEM_ADDR   = pc_q;
  assign ALU_OP      = alu_op_q;
  assign ALU_FUNC    = alu_func_q;
  assign ALU_FLAG_IN = flag_q;
  assign ALU_OVF_IN  = ovf_q;
  assign DMEM_REQ    = dmem_req_q;
  assign DMEM_WE     = dmem_we_q;
  assign REG_WE      = reg_we_q;
  assign REG_WADDR   = instr_q[5:3];
  assign DONE        = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected fetch addresses and write-back
// registers are queued at stimulus time and popped when the DUT produces them.
module tb_alu_sequencer;
  localparam logic [7:0] HALT = 8'h03;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       imem_req, imem_ack = 1'b0;
  logic [7:0] imem_addr;
  logic [8:0] imem_data = '0;
  logic [2:0] alu_op, alu_func;
  logic       alu_flag_in, alu_ovf_in;
  logic       alu_flag_out = 1'b0, alu_ovf_out = 1'b0, alu_br_en = 1'b0;
  logic       dmem_req, dmem_we, dmem_ack = 1'b0;
  logic       reg_we;
  logic [2:0] reg_waddr;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] pc = 8'd0;
  logic [7:0] exp_fetch[$];
  logic [2:0] exp_wb[$];
  logic       prev_req = 1'b0, prev_we = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(8), .HALT_ADDR(HALT)) dut (
    .CLK(clk), .RESET(rst), .START(start),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_ACK(imem_ack), .IMEM_DATA(imem_data),
    .ALU_OP(alu_op), .ALU_FUNC(alu_func), .ALU_FLAG_IN(alu_flag_in), .ALU_OVF_IN(alu_ovf_in),
    .ALU_FLAG_OUT(alu_flag_out), .ALU_OVF_OUT(alu_ovf_out), .ALU_BR_EN(alu_br_en),
    .DMEM_REQ(dmem_req), .DMEM_WE(dmem_we), .DMEM_ACK(dmem_ack),
    .REG_WE(reg_we), .REG_WADDR(reg_waddr), .DONE(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever a fetch starts or a write-back pulses
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      prev_we  = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        if (exp_fetch.size() == 0) check("fetch_unexp", imem_req, 0);
        else check("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
      if (reg_we) begin
        if (exp_wb.size() == 0) check("regwe_unexp", reg_we, 0);
        else check("reg_waddr", reg_waddr, exp_wb.pop_front());
        check("regwe_pulse", prev_we, 0);
      end
      prev_req = imem_req;
      prev_we  = reg_we;
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch_seen", imem_req, 1);
  endtask

  task automatic do_start();
    pc = 8'd0;
    exp_fetch.push_back(8'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done", done, 0);
    check("start_req", imem_req, 1);
  endtask

  task automatic run_instr(input logic [8:0] ins, input logic fl, input logic ov,
                           input logic br, input int iwait, input int dwait);
    logic [2:0] op;
    logic [7:0] npc;
    logic       is_mem, is_br, to_halt;
    int         cnt;
    op      = ins[8:6];
    is_mem  = (op == 3'b000) || (op == 3'b001);
    is_br   = (op == 3'b100) || (op == 3'b101) || (op == 3'b111 && ins[2:1] == 2'b11);
    npc     = br ? pc + 8'd1 + {{5{ins[5]}}, ins[5:3]} : pc + 8'd1;
    to_halt = (npc == HALT);
    wait_fetch();
    for (int i = 0; i < iwait; i++) begin
      @(negedge clk);
      check("imem_hold", imem_req, 1);
    end
    imem_ack = 1'b1; imem_data = ins;
    alu_flag_out = fl; alu_ovf_out = ov; alu_br_en = br;
    if (!to_halt) exp_fetch.push_back(npc);
    if (!is_br && op != 3'b001) exp_wb.push_back(ins[5:3]);
    @(negedge clk);
    imem_ack = 1'b0;
    check("imem_drop", imem_req, 0);
    @(negedge clk);
    check("alu_op", alu_op, op);
    check("alu_func", alu_func, ins[2:0]);
    @(negedge clk);
    check("flag", alu_flag_in, fl);
    check("ovf", alu_ovf_in, ov);
    if (is_mem) begin
      cnt = 0;
      check("dmem_we", dmem_we, (op == 3'b001));
      for (int i = 0; i < dwait; i++) begin
        if (dmem_req) cnt++;
        @(negedge clk);
      end
      dmem_ack = 1'b1;
      if (dmem_req) cnt++;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("dmem_req_cycles", cnt, dwait + 1);
      check("dmem_drop", dmem_req, 0);
      if (op == 3'b000) begin
        check("wb_after_ack", reg_we, 1);
        @(negedge clk);
      end else begin
        check("sw_no_wb", reg_we, 0);
      end
    end else if (!is_br) begin
      check("wb_pulse", reg_we, 1);
      @(negedge clk);
    end else begin
      check("br_no_wb", reg_we, 0);
    end
    if (to_halt) begin
      check("done", done, 1);
      check("halt_no_req", imem_req, 0);
    end else begin
      check("next_fetch", imem_req, 1);
    end
    alu_br_en = 1'b0;
    pc = npc;
    $display("instr %b pc->%02h flag=%0d ovf=%0d", ins, npc, alu_flag_in, alu_ovf_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_done", done, 0);
    check("rst_flag", alu_flag_in, 0);
    check("rst_ovf", alu_ovf_in, 0);
    check("rst_pc", imem_addr, 0);
    check("rst_alu_op", alu_op, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_req", imem_req, 0);

    do_start();
    run_instr(9'b010_011_000, 1'b0, 1'b1, 1'b0, 0, 0); // ADD rd3       0->1
    run_instr(9'b110_001_000, 1'b1, 1'b0, 1'b0, 0, 0); // SEI rd1       1->2
    run_instr(9'b111_001_110, 1'b1, 1'b0, 1'b1, 0, 0); // B0 +1         2->4
    run_instr(9'b100_000_000, 1'b1, 1'b0, 1'b0, 0, 0); // CEQ           4->5
    run_instr(9'b111_110_111, 1'b1, 1'b1, 1'b1, 0, 0); // B1 -2         5->4
    run_instr(9'b000_101_000, 1'b0, 1'b1, 1'b0, 0, 3); // LW rd5        4->5
    run_instr(9'b001_010_000, 1'b1, 1'b0, 1'b0, 0, 1); // SW            5->6
    run_instr(9'b111_111_001, 1'b0, 1'b0, 1'b0, 2, 0); // SHL_F rd7     6->7

    // Reset while a load is waiting on the data memory
    wait_fetch();
    imem_ack = 1'b1; imem_data = 9'b000_101_000;
    alu_flag_out = 1'b1; alu_ovf_out = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_mem_req", dmem_req, 1);
    check("mid_mem_flag", alu_flag_in, 1);
    #2 rst = 1'b1;
    #1;
    check("async_dmem_drop", dmem_req, 0);
    check("async_pc", imem_addr, 0);
    check("async_flag", alu_flag_in, 0);
    check("async_ovf", alu_ovf_in, 0);
    $display("reset asserted mid-MEM");
    @(negedge clk);
    rst = 1'b0;
    pc = 8'd0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", imem_req, 0);

    do_start();
    run_instr(9'b111_100_110, 1'b0, 1'b0, 1'b1, 0, 0); // B0 -4         0->FD
    run_instr(9'b010_001_000, 1'b0, 1'b1, 1'b0, 0, 0); // ADD rd1       FD->FE
    run_instr(9'b111_011_111, 1'b0, 1'b0, 1'b1, 0, 0); // B1 +3         FE->02
    run_instr(9'b101_000_000, 1'b1, 1'b0, 1'b0, 0, 0); // CLT           02->03 halt
    repeat (5) begin
      @(negedge clk);
      check("halt_idle_req", imem_req, 0);
    end
    check("halt_done_hold", done, 1);

    do_start();
    check("flag_keep", alu_flag_in, 1);
    run_instr(9'b010_010_000, 1'b1, 1'b0, 1'b0, 0, 0); // ADD rd2       0->1
    run_instr(9'b011_100_000, 1'b0, 1'b1, 1'b0, 1, 0); // SUB rd4       1->2
    run_instr(9'b111_110_011, 1'b1, 1'b1, 1'b0, 0, 0); // SHR_X rd6     2->3 halt
    repeat (3) @(negedge clk);
    check("final_done", done, 1);
    check("final_no_req", imem_req, 0);
    check("fetch_q_left", exp_fetch.size(), 0);
    check("wb_q_left", exp_wb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
